// File: rtl/hazard_stall_controller_if.sv
// Decode-stage hazard bus: operand/destination info in, stall/flush and mult/div status out.
// The controller uses the slave view; the pipeline (or a bench) drives through the master view.
interface hazard_stall_controller_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] Rs_D;
    logic [REG_ADDR_W-1:0] Rt_D;
    logic                  Branch_D;
    logic                  MD_Start_D;
    logic                  MD_Read_D;
    logic [REG_ADDR_W-1:0] Write_Reg_E;
    logic                  Reg_Write_E;
    logic                  Mem_To_Reg_E;
    logic [REG_ADDR_W-1:0] Write_Reg_M;
    logic                  Mem_To_Reg_M;
    logic                  Stall_F;
    logic                  Stall_D;
    logic                  Flush_E;
    logic                  MD_Busy;
    logic                  MD_Done;
    logic [CNT_W-1:0]      Stall_Count;

    modport master (
        output Rs_D, Rt_D, Branch_D, MD_Start_D, MD_Read_D,
               Write_Reg_E, Reg_Write_E, Mem_To_Reg_E, Write_Reg_M, Mem_To_Reg_M,
        input  Stall_F, Stall_D, Flush_E, MD_Busy, MD_Done, Stall_Count
    );

    modport slave (
        input  Rs_D, Rt_D, Branch_D, MD_Start_D, MD_Read_D,
               Write_Reg_E, Reg_Write_E, Mem_To_Reg_E, Write_Reg_M, Mem_To_Reg_M,
        output Stall_F, Stall_D, Flush_E, MD_Busy, MD_Done, Stall_Count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Decode-stage stall/flush generator: load-use, branch-operand and mult/div hazards,
// plus the mult/div sequencer and a saturating stalled-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_stall_controller_if.slave bus
);
    localparam int unsigned LAT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [LAT_W-1:0] r_cnt;
    logic             r_md_busy;
    logic             r_md_done;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lw_stall;
    logic w_br_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_accept;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic f_match(input logic [REG_ADDR_W-1:0] x,
                                     input logic [REG_ADDR_W-1:0] r);
        return (r != '0) && (x == r);
    endfunction

    always_comb begin
        w_lw_stall = bus.Mem_To_Reg_E &&
                     (f_match(bus.Rs_D, bus.Write_Reg_E) || f_match(bus.Rt_D, bus.Write_Reg_E));
        w_br_stall = bus.Branch_D &&
                     ((bus.Reg_Write_E &&
                       (f_match(bus.Rs_D, bus.Write_Reg_E) || f_match(bus.Rt_D, bus.Write_Reg_E))) ||
                      (bus.Mem_To_Reg_M &&
                       (f_match(bus.Rs_D, bus.Write_Reg_M) || f_match(bus.Rt_D, bus.Write_Reg_M))));
        w_md_stall = (r_state == S_RUN) && (bus.MD_Start_D || bus.MD_Read_D);
        w_stall    = w_lw_stall || w_br_stall || w_md_stall;
        w_accept   = bus.MD_Start_D && !w_lw_stall && !w_br_stall && (r_state != S_RUN);
    end

    // Stall lines are combinational so the hazard is held off in the same cycle.
    assign bus.Stall_F     = rst_n & w_stall;
    assign bus.Stall_D     = rst_n & w_stall;
    assign bus.Flush_E     = rst_n & w_stall;
    assign bus.MD_Busy     = r_md_busy;
    assign bus.MD_Done     = r_md_done;
    assign bus.Stall_Count = r_stall_cnt;

    // Mult/div sequencer; DONE behaves like IDLE so a new op can issue without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        r_md_busy <= 1'b0;
                        r_md_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    r_md_done <= 1'b0;
                    if (w_accept) begin
                        r_state   <= S_RUN;
                        r_cnt     <= LAT_W'(MD_LATENCY - 1);
                        r_md_busy <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_md_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule
